// File: rtl/inst_queue_pkg.sv
// ---------------------------------------------------------------------------
// inst_queue_pkg
// Shared widths and defaults for the instruction queue that sits between
// the instruction fetcher and the decoder.
//   INSTRUCTION_WIDTH      width of one fetched instruction word
//   ADDRESS_WIDTH          width of a program counter
//   INST_QUEUE_DEPTH_LOG2  default log2 of the queue entry count
//   NULL_INST / NULL_ADDR  value driven on idle data outputs
// ---------------------------------------------------------------------------
package inst_queue_pkg;

  localparam int INSTRUCTION_WIDTH     = 32;
  localparam int ADDRESS_WIDTH         = 32;
  localparam int INST_QUEUE_DEPTH_LOG2 = 4;

  localparam logic [INSTRUCTION_WIDTH-1:0] NULL_INST = '0;
  localparam logic [ADDRESS_WIDTH-1:0]     NULL_ADDR = '0;

endpackage : inst_queue_pkg

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
// Circular FIFO of {instruction, pc} pairs between the fetcher and the
// combinational decoder. The head is presented show-ahead and is popped when
// the dispatcher accepts it. A ROB flush discards the whole contents.
//
// Ports
//   clk_in               clock, state updates on rising edge
//   rst_in               asynchronous active-low reset
//   rdy_in               global ready; 0 freezes all state
//   rob_flush_in         misprediction flush, empties the queue
//   ifetch_en_in         fetcher push request
//   ifetch_inst_in       instruction to push
//   ifetch_pc_in         pc of the pushed instruction
//   ifetch_full_out      queue full, fetcher must not push
//   dispatcher_ready_in  downstream accepts the presented head
//   decoder_inst_en_out  head valid
//   decoder_inst_out     head instruction (zero when not valid)
//   decoder_pc_out       head pc (zero when not valid)
//
// Build option
//   INST_QUEUE_BYPASS_EN  when defined, a push into an empty queue is shown
//                         to the decoder in the same cycle; if it is accepted
//                         immediately it is never written into storage.
// ---------------------------------------------------------------------------
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH_LOG2 = INST_QUEUE_DEPTH_LOG2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         rob_flush_in,
  input  logic                         ifetch_en_in,
  input  logic [INSTRUCTION_WIDTH-1:0] ifetch_inst_in,
  input  logic [ADDRESS_WIDTH-1:0]     ifetch_pc_in,
  output logic                         ifetch_full_out,
  input  logic                         dispatcher_ready_in,
  output logic                         decoder_inst_en_out,
  output logic [INSTRUCTION_WIDTH-1:0] decoder_inst_out,
  output logic [ADDRESS_WIDTH-1:0]     decoder_pc_out
);

  localparam int                  DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [INSTRUCTION_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [ADDRESS_WIDTH-1:0]     pc_mem_q   [DEPTH];

  logic [DEPTH_LOG2-1:0] head_q, head_d;
  logic [DEPTH_LOG2-1:0] tail_q, tail_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic empty, full, active, head_vld, push, pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_CNT);
    // Queue is live only when globally ready and not being flushed.
    active   = rdy_in && !rob_flush_in;
    head_vld = !empty && active;

    push = ifetch_en_in && !full && active;
    pop  = head_vld && dispatcher_ready_in;

    decoder_inst_en_out = head_vld;
    decoder_inst_out    = head_vld ? inst_mem_q[head_q] : NULL_INST;
    decoder_pc_out      = head_vld ? pc_mem_q[head_q]   : NULL_ADDR;
    ifetch_full_out     = full;

`ifdef INST_QUEUE_BYPASS_EN
    // Empty queue: forward the incoming pair straight to the decoder. It is
    // stored only if the dispatcher does not take it this cycle. rst_in keeps
    // the outputs quiet while reset is asserted.
    if (empty && active && ifetch_en_in && rst_in) begin
      decoder_inst_en_out = 1'b1;
      decoder_inst_out    = ifetch_inst_in;
      decoder_pc_out      = ifetch_pc_in;
      push                = !dispatcher_ready_in;
    end
`endif

    // Pointers wrap naturally at DEPTH; count tells full from empty.
    head_d  = head_q + DEPTH_LOG2'(pop);
    tail_d  = tail_q + DEPTH_LOG2'(push);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (rob_flush_in) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
      end
    end
  end

  // Storage has no reset; entries are only read between tail and head.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem_q[tail_q] <= ifetch_inst_in;
      pc_mem_q[tail_q]   <= ifetch_pc_in;
    end
  end

endmodule : inst_queue

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue
// Self-checking bench for inst_queue: a table of directed vectors followed by
// multi-cycle sequences (fill/drain, wrap, flush, stall, bypass, reset), all
// checked against a queue-based reference of the FIFO contents.
// ---------------------------------------------------------------------------
module tb_inst_queue;
  import inst_queue_pkg::*;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_flush_in;
  logic        ifetch_en_in;
  logic [31:0] ifetch_inst_in;
  logic [31:0] ifetch_pc_in;
  logic        ifetch_full_out;
  logic        dispatcher_ready_in;
  logic        decoder_inst_en_out;
  logic [31:0] decoder_inst_out;
  logic [31:0] decoder_pc_out;

  inst_queue dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .rob_flush_in        (rob_flush_in),
    .ifetch_en_in        (ifetch_en_in),
    .ifetch_inst_in      (ifetch_inst_in),
    .ifetch_pc_in        (ifetch_pc_in),
    .ifetch_full_out     (ifetch_full_out),
    .dispatcher_ready_in (dispatcher_ready_in),
    .decoder_inst_en_out (decoder_inst_en_out),
    .decoder_inst_out    (decoder_inst_out),
    .decoder_pc_out      (decoder_pc_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];

  typedef struct {
    logic        r;
    logic        f;
    logic        e;
    logic [31:0] pc;
    logic        d;
    logic        exp_en;
    logic [31:0] exp_pc;
    logic        exp_full;
  } vec_t;

  vec_t tbl[7];

  logic        obs_en;
  logic [31:0] obs_pc;
  logic        obs_full;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h0000_0013 + (pc >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // reference, then advance the reference at the clock edge.
  task automatic cycle(input logic r, input logic f, input logic e,
                       input logic [31:0] p, input logic d, input string tag);
    int          sz;
    logic        byp;
    logic        head_ok;
    logic        exp_en;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_full;
    ent_t        ne;
    rdy_in              = r;
    rob_flush_in        = f;
    ifetch_en_in        = e;
    ifetch_pc_in        = p;
    ifetch_inst_in      = inst_of(p);
    dispatcher_ready_in = d;
    #3;
    sz      = sb.size();
    byp     = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp     = (sz == 0) && !f && r && e;
`endif
    head_ok  = (sz != 0) && !f && r;
    exp_en   = byp || head_ok;
    exp_pc   = 32'h0;
    exp_inst = 32'h0;
    if (byp) begin
      exp_pc   = p;
      exp_inst = inst_of(p);
    end else if (head_ok) begin
      exp_pc   = sb[0].pc;
      exp_inst = sb[0].inst;
    end
    exp_full = (sz == 16);
    chk({tag, "_en"},   {31'b0, decoder_inst_en_out}, {31'b0, exp_en});
    chk({tag, "_pc"},   decoder_pc_out,   exp_pc);
    chk({tag, "_inst"}, decoder_inst_out, exp_inst);
    chk({tag, "_full"}, {31'b0, ifetch_full_out}, {31'b0, exp_full});
    obs_en   = decoder_inst_en_out;
    obs_pc   = decoder_pc_out;
    obs_full = ifetch_full_out;
    @(posedge clk_in);
    ne.inst = inst_of(p);
    ne.pc   = p;
    if (r && f) begin
      sb.delete();
    end else if (r) begin
      if (byp) begin
        if (!d) sb.push_back(ne);
      end else begin
        if (head_ok && d) void'(sb.pop_front());
        if (e && sz != 16) sb.push_back(ne);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in              = 1'b1;
    rob_flush_in        = 1'b0;
    ifetch_en_in        = 1'b0;
    ifetch_pc_in        = 32'h0;
    ifetch_inst_in      = 32'h0;
    dispatcher_ready_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors starting from an empty queue.
`ifdef INST_QUEUE_BYPASS_EN
    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0};
`else
    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h000, 1'b0};
`endif
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 32'h100, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 32'h100, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 32'h104, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h10c, 1'b1, 1'b0, 32'h000, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 1'b0, 32'h000, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 1'b0};

    // Reset state.
    idle_inputs();
    rst_in = 1'b0;
    #3;
    chk("reset_en",   {31'b0, decoder_inst_en_out}, 32'h0);
    chk("reset_pc",   decoder_pc_out,   32'h0);
    chk("reset_inst", decoder_inst_out, 32'h0);
    chk("reset_full", {31'b0, ifetch_full_out}, 32'h0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    foreach (tbl[i]) begin
      cycle(tbl[i].r, tbl[i].f, tbl[i].e, tbl[i].pc, tbl[i].d, "tbl");
      chk("tbl_vec_en",   {31'b0, obs_en},   {31'b0, tbl[i].exp_en});
      chk("tbl_vec_pc",   obs_pc,            tbl[i].exp_pc);
      chk("tbl_vec_full", {31'b0, obs_full}, {31'b0, tbl[i].exp_full});
    end

    // Fill to 16 with the dispatcher stalled.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1, 32'(4 * i), 1'b0, "fill");
    cycle(1'b1, 1'b0, 1'b1, 32'hDEAD0, 1'b0, "push_full");
    chk("full_flag", {31'b0, obs_full}, 32'h1);
    // Full with a simultaneous pop: the push must still be dropped.
    cycle(1'b1, 1'b0, 1'b1, 32'hBEEF0, 1'b1, "full_pop");
    chk("full_pop_pc", obs_pc, 32'h0);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "drain");
      chk("drain_order", obs_pc, 32'(4 * i));
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "drained");
    chk("drained_en", {31'b0, obs_en}, 32'h0);

    // Move head/tail to 14, then hold 15 entries while pushing and popping.
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), 1'b0, "adv_push");
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "adv_pop");
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b1, 32'h2000 + 32'(4 * i), 1'b0, "pre_wrap");
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 32'h2000 + 32'(4 * (15 + i)), 1'b1, "wrap");
      chk("wrap_pc",   obs_pc, 32'h2000 + 32'(4 * i));
      chk("wrap_full", {31'b0, obs_full}, 32'h0);
    end

    // Reduce to 7 entries, then flush together with push and pop.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "pre_flush");
    cycle(1'b1, 1'b1, 1'b1, 32'h3000, 1'b1, "flush");
    chk("flush_en", {31'b0, obs_en}, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "post_flush");
    chk("post_flush_en", {31'b0, obs_en}, 32'h0);

    // Push into an empty queue with the dispatcher ready.
    cycle(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, "byp");
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_same_en", {31'b0, obs_en}, 32'h1);
    chk("byp_same_pc", obs_pc, 32'h100);
`else
    chk("byp_same_en", {31'b0, obs_en}, 32'h0);
`endif
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "byp_next");
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_next_en", {31'b0, obs_en}, 32'h0);
`else
    chk("byp_next_en", {31'b0, obs_en}, 32'h1);
    chk("byp_next_pc", obs_pc, 32'h100);
`endif

    // rdy_in stall with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h400 + 32'(4 * i), 1'b0, "stall_fill");
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'h500, 1'b1, "stall");
      chk("stall_en", {31'b0, obs_en}, 32'h0);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "unstall");
    chk("unstall_pc", obs_pc, 32'h400);

    // Asynchronous reset mid-stream with five entries.
    cycle(1'b1, 1'b0, 1'b1, 32'h40c, 1'b0, "rst_fill");
    cycle(1'b1, 1'b0, 1'b1, 32'h410, 1'b0, "rst_fill");
    idle_inputs();
    #3;
    rst_in = 1'b0;
    #1;
    chk("async_rst_en",   {31'b0, decoder_inst_en_out}, 32'h0);
    chk("async_rst_pc",   decoder_pc_out,   32'h0);
    chk("async_rst_inst", decoder_inst_out, 32'h0);
    chk("async_rst_full", {31'b0, ifetch_full_out}, 32'h0);
    sb.delete();
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, "after_rst");
    chk("after_rst_en", {31'b0, obs_en}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_inst_queue
